// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, main control decoder and sign
// extender, with all results captured in the ID/EX pipeline latch.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_NPC  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_id_instr,
  input  logic [31:0]           if_id_npc,
  input  logic                  ex_mem_pc_src,
  input  logic                  mem_wb_reg_write,
  input  logic [4:0]            mem_wb_write_reg,
  input  logic [DATA_WIDTH-1:0] mem_wb_write_data,
  output logic [1:0]            id_ex_wb,
  output logic [2:0]            id_ex_m,
  output logic [3:0]            id_ex_ex,
  output logic [31:0]           id_ex_npc,
  output logic [DATA_WIDTH-1:0] id_ex_rd1,
  output logic [DATA_WIDTH-1:0] id_ex_rd2,
  output logic [31:0]           id_ex_sign_ext,
  output logic [4:0]            id_ex_rt,
  output logic [4:0]            id_ex_rd
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000
  } opcode_e;

  typedef struct packed {
    logic [1:0] wb;  // {reg_write, mem_to_reg}
    logic [2:0] m;   // {branch, mem_read, mem_write}
    logic [3:0] ex;  // {reg_dst, alu_op[1:0], alu_src}
  } ctrl_t;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [32];
  logic                  wr_en;

  assign wr_en = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

  // NOTE: the array sits in the reset branch because the architecture requires
  // every register to read 0 after reset; this forces flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[mem_wb_write_reg] <= mem_wb_write_data;
    end
  end

  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  // Write-through bypass lets the instruction in decode see a same-cycle writeback.
  always_comb begin
    if (rs == 5'd0)                             rd1 = '0;
    else if (wr_en && mem_wb_write_reg == rs)   rd1 = mem_wb_write_data;
    else                                        rd1 = regs_q[rs];

    if (rt == 5'd0)                             rd2 = '0;
    else if (wr_en && mem_wb_write_reg == rt)   rd2 = mem_wb_write_data;
    else                                        rd2 = regs_q[rt];
  end

  // ---------------------------------------------------------------------------
  // Main control decoder
  // ---------------------------------------------------------------------------
  ctrl_t ctrl;

  // NOTE: the default is assigned first so every path drives ctrl and no latch
  // is inferred for unlisted opcodes; they decode as a bubble.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: ctrl = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
      OP_LW:    ctrl = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
      OP_SW:    ctrl = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
      OP_BEQ:   ctrl = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
      OP_ADDI:  ctrl = '{wb: 2'b10, m: 3'b000, ex: 4'b0001};
      default:  ctrl = '0;
    endcase
  end

  logic [31:0] sign_ext;
  assign sign_ext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

  // ---------------------------------------------------------------------------
  // ID/EX pipeline latch
  // ---------------------------------------------------------------------------
  ctrl_t                 ctrl_d, ctrl_q;
  logic [31:0]           npc_q;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q;
  logic [31:0]           sign_ext_q;
  logic [4:0]            rt_q, rd_q;

  assign ctrl_d = ex_mem_pc_src ? ctrl_t'('0) : ctrl;

  // NOTE: non-blocking assignments keep every latch field sampling the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      npc_q      <= RESET_NPC;
      rd1_q      <= '0;
      rd2_q      <= '0;
      sign_ext_q <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      npc_q      <= if_id_npc;
      rd1_q      <= rd1;
      rd2_q      <= rd2;
      sign_ext_q <= sign_ext;
      rt_q       <= rt;
      rd_q       <= rd;
    end
  end

  assign id_ex_wb       = ctrl_q.wb;
  assign id_ex_m        = ctrl_q.m;
  assign id_ex_ex       = ctrl_q.ex;
  assign id_ex_npc      = npc_q;
  assign id_ex_rd1      = rd1_q;
  assign id_ex_rd2      = rd2_q;
  assign id_ex_sign_ext = sign_ext_q;
  assign id_ex_rt       = rt_q;
  assign id_ex_rd       = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, writeback/read,
// bypass, $0 protection, flush, opcode decode and asynchronous reset.
module tb_decode_stage;

  localparam logic [31:0] RST_NPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        ex_mem_pc_src;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] mem_wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_rd1;
  logic [31:0] id_ex_rd2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.DATA_WIDTH(32), .RESET_NPC(RST_NPC)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_instr       (if_id_instr),
    .if_id_npc         (if_id_npc),
    .ex_mem_pc_src     (ex_mem_pc_src),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_write_reg  (mem_wb_write_reg),
    .mem_wb_write_data (mem_wb_write_data),
    .id_ex_wb          (id_ex_wb),
    .id_ex_m           (id_ex_m),
    .id_ex_ex          (id_ex_ex),
    .id_ex_npc         (id_ex_npc),
    .id_ex_rd1         (id_ex_rd1),
    .id_ex_rd2         (id_ex_rd2),
    .id_ex_sign_ext    (id_ex_sign_ext),
    .id_ex_rt          (id_ex_rt),
    .id_ex_rd          (id_ex_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic pc_src,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    if_id_instr       = instr;
    if_id_npc         = npc;
    ex_mem_pc_src     = pc_src;
    mem_wb_reg_write  = we;
    mem_wb_write_reg  = wreg;
    mem_wb_write_data = wdata;
  endtask

  initial begin
    // Reset held across several edges with live stimulus on the inputs.
    rst = 1'b0;
    drive(32'h00A6_3020, 32'h0000_0044, 1'b0, 1'b1, 5'd5, 32'h5555_5555);
    step();
    step();
    check("rst_wb",   {30'd0, id_ex_wb},  32'd0);
    check("rst_m",    {29'd0, id_ex_m},   32'd0);
    check("rst_ex",   {28'd0, id_ex_ex},  32'd0);
    check("rst_npc",  id_ex_npc,          RST_NPC);
    check("rst_rd1",  id_ex_rd1,          32'd0);
    check("rst_sext", id_ex_sign_ext,     32'd0);
    check("rst_rd",   {27'd0, id_ex_rd},  32'd0);
    #3 rst = 1'b1;

    // add $6,$5,$6 right after reset: $5 reads 0.
    drive(32'h00A6_3020, 32'h0000_0100, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("post_rst_rd1", id_ex_rd1,          32'd0);
    check("post_rst_npc", id_ex_npc,          32'h0000_0100);
    check("post_rst_ex",  {28'd0, id_ex_ex},  32'b1100);

    // Write $5 while decoding the all-zero instruction (R-type).
    drive(32'h0000_0000, 32'h0000_0104, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    check("nop_wb",  {30'd0, id_ex_wb}, 32'b10);
    check("nop_rd1", id_ex_rd1,         32'd0);

    // add $6,$5,$6 reads the committed $5.
    drive(32'h00A6_3020, 32'h0000_0108, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("add_rd1", id_ex_rd1,         32'hDEAD_BEEF);
    check("add_rd2", id_ex_rd2,         32'd0);
    check("add_ex",  {28'd0, id_ex_ex}, 32'b1100);
    check("add_wb",  {30'd0, id_ex_wb}, 32'b10);
    check("add_m",   {29'd0, id_ex_m},  32'b000);
    check("add_rd",  {27'd0, id_ex_rd}, 32'd6);
    check("add_rt",  {27'd0, id_ex_rt}, 32'd6);

    // lw $8,-4($7) with same-cycle writeback of $7 (rs bypass).
    drive(32'h8CE8_FFFC, 32'h0000_010C, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
    step();
    check("lw_rd1",  id_ex_rd1,         32'h0000_1234);
    check("lw_sext", id_ex_sign_ext,    32'hFFFF_FFFC);
    check("lw_wb",   {30'd0, id_ex_wb}, 32'b11);
    check("lw_m",    {29'd0, id_ex_m},  32'b010);
    check("lw_ex",   {28'd0, id_ex_ex}, 32'b0001);
    check("lw_rt",   {27'd0, id_ex_rt}, 32'd8);

    // add $6,$5,$6 with same-cycle writeback of $6 (rt bypass).
    drive(32'h00A6_3020, 32'h0000_0110, 1'b0, 1'b1, 5'd6, 32'h0000_CAFE);
    step();
    check("byp_rt_rd2", id_ex_rd2, 32'h0000_CAFE);
    check("byp_rt_rd1", id_ex_rd1, 32'hDEAD_BEEF);

    // addi $0,$0,5 while writing $0: no bypass, no commit.
    drive(32'h2000_0005, 32'h0000_0114, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    check("r0_byp_rd1", id_ex_rd1,         32'd0);
    check("addi_wb",    {30'd0, id_ex_wb}, 32'b10);
    check("addi_ex",    {28'd0, id_ex_ex}, 32'b0001);
    check("addi_sext",  id_ex_sign_ext,    32'd5);
    drive(32'h2000_0005, 32'h0000_0118, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("r0_rd1", id_ex_rd1, 32'd0);

    // beq $5,$6,3 flushed, with a writeback of $9 in the same cycle.
    drive(32'h10A6_0003, 32'h0000_011C, 1'b1, 1'b1, 5'd9, 32'h0000_0099);
    step();
    check("flush_wb",   {30'd0, id_ex_wb}, 32'd0);
    check("flush_m",    {29'd0, id_ex_m},  32'd0);
    check("flush_ex",   {28'd0, id_ex_ex}, 32'd0);
    check("flush_sext", id_ex_sign_ext,    32'd3);
    check("flush_rd1",  id_ex_rd1,         32'hDEAD_BEEF);
    check("flush_npc",  id_ex_npc,         32'h0000_011C);

    // Same beq not flushed.
    drive(32'h10A6_0003, 32'h0000_0120, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("beq_wb",   {30'd0, id_ex_wb}, 32'b00);
    check("beq_m",    {29'd0, id_ex_m},  32'b100);
    check("beq_ex",   {28'd0, id_ex_ex}, 32'b0010);
    check("beq_sext", id_ex_sign_ext,    32'd3);
    check("beq_rd2",  id_ex_rd2,         32'h0000_CAFE);

    // lw $1,0($9): writeback during the flush committed.
    drive(32'h8D21_0000, 32'h0000_0124, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("flush_wr_rd1", id_ex_rd1, 32'h0000_0099);

    // sw $0,0($0).
    drive(32'hAC00_0000, 32'h0000_0128, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("sw_wb", {30'd0, id_ex_wb}, 32'b00);
    check("sw_m",  {29'd0, id_ex_m},  32'b001);
    check("sw_ex", {28'd0, id_ex_ex}, 32'b0001);

    // Unknown opcode 0x3F decodes as a bubble.
    drive(32'hFC00_8000, 32'h0000_012C, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("unk_wb",   {30'd0, id_ex_wb}, 32'd0);
    check("unk_m",    {29'd0, id_ex_m},  32'd0);
    check("unk_ex",   {28'd0, id_ex_ex}, 32'd0);
    check("unk_sext", id_ex_sign_ext,    32'hFFFF_8000);

    // Load a live lw into ID/EX, then assert reset between edges.
    drive(32'h8CE8_FFFC, 32'h0000_0130, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("pre_arst_wb", {30'd0, id_ex_wb}, 32'b11);
    #2;
    drive(32'h8CE8_FFFC, 32'h0000_0134, 1'b0, 1'b1, 5'd5, 32'h0000_0001);
    rst = 1'b0;
    #1;
    check("arst_wb",   {30'd0, id_ex_wb}, 32'd0);
    check("arst_m",    {29'd0, id_ex_m},  32'd0);
    check("arst_npc",  id_ex_npc,         RST_NPC);
    check("arst_rd1",  id_ex_rd1,         32'd0);
    check("arst_sext", id_ex_sign_ext,    32'd0);
    step();
    #3 rst = 1'b1;

    // $5 and $7 were cleared and the writeback under reset was discarded.
    drive(32'h00A7_3020, 32'h0000_0138, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("arst_r5", id_ex_rd1, 32'd0);
    check("arst_r7", id_ex_rd2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage; the consumer of the IF/ID latch outputs (instruction word and next PC) produced by the fetch stage.
- Contains the 32x32 register file, main control decoder and sign extender.
- Registers all results into the ID/EX pipeline latch.
- Accepts MEM/WB writeback into the register file, and the EX/MEM branch-taken signal to squash the instruction being decoded.

Parameters:
- DATA_WIDTH, 32, register/datapath width. Instruction and NPC stay 32 bits.
- RESET_NPC, 32'h0000_0000, value loaded into id_ex_npc on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- if_id_instr  in  32  instruction from the IF/ID latch.
- if_id_npc  in  32  PC+4 from the IF/ID latch.
- ex_mem_pc_src  in  1  branch taken. The instruction in decode is squashed.
- mem_wb_reg_write  in  1  writeback enable.
- mem_wb_write_reg  in  5  writeback register index.
- mem_wb_write_data  in  DATA_WIDTH  writeback data.
- id_ex_wb  out  2  {reg_write, mem_to_reg}.
- id_ex_m  out  3  {branch, mem_read, mem_write}.
- id_ex_ex  out  4  {reg_dst, alu_op[1:0], alu_src}.
- id_ex_npc  out  32  latched next PC.
- id_ex_rd1  out  DATA_WIDTH  latched rs value.
- id_ex_rd2  out  DATA_WIDTH  latched rt value.
- id_ex_sign_ext  out  32  latched sign-extended instr[15:0].
- id_ex_rt  out  5  latched instr[20:16].
- id_ex_rd  out  5  latched instr[15:11].

Behaviour:
- Reset (rst=0, asynchronous):
  - All 32 registers are cleared to 0.
  - Every ID/EX output is cleared to 0, except id_ex_npc, which is set to RESET_NPC.
  - Reset asserted mid-operation discards any writeback in that cycle.
- Register file:
  - Write occurs on the rising edge when mem_wb_reg_write=1 and mem_wb_write_reg!=0. Writes to $0 are ignored; $0 always reads 0.
  - Reads are combinational on instr[25:21] (rs) and instr[20:16] (rt).
  - Write-through bypass: if a write is enabled this cycle to a nonzero register equal to rs or rt, the read returns mem_wb_write_data. The decoded instruction therefore sees the new value in the same cycle.
- Control decode on opcode instr[31:26], given as wb / m / ex:
  - 000000 R-type: 10 / 000 / 1100.
  - 100011 lw: 11 / 010 / 0001.
  - 101011 sw: 00 / 001 / 0001.
  - 000100 beq: 00 / 100 / 0010.
  - 001000 addi: 10 / 000 / 0001.
  - Any other opcode: all control bits 0 (bubble).
- Sign extension: instr[15] is replicated into bits 31:16.
- ID/EX latch:
  - Every rising edge (no stall input), all outputs load from the current decode. Latency is 1 cycle from if_id_* to id_ex_*.
- Flush:
  - If ex_mem_pc_src=1 at the edge, id_ex_wb, id_ex_m and id_ex_ex load 0.
  - Data fields (npc, rd1, rd2, sign_ext, rt, rd) load normally; they are don't-care for a bubble but must be deterministic.
  - Flush and writeback in the same cycle: the writeback still commits.
- The all-zero instruction (sll $0,$0,0) decodes as R-type. It is harmless because writes to $0 are ignored.

Test Plan:
- Reset: hold rst=0, then release → all id_ex_* = 0 and id_ex_npc = RESET_NPC. Afterwards, any instruction with rs=5 reads rd1 = 0.
- Writeback then read: write $5 = 32'hDEAD_BEEF. Next cycle, instr 0x00A63020 (add $6,$5,$6) → id_ex_rd1 = DEAD_BEEF, id_ex_ex = 1100, id_ex_wb = 10, id_ex_rd = 6.
- Same-cycle bypass: write $7 = 32'h1234 while instr = 0x8CE8FFFC (lw $8,-4($7)) → id_ex_rd1 = 1234, id_ex_sign_ext = FFFF_FFFC, id_ex_wb = 11, id_ex_m = 010, id_ex_rt = 8.
- $0 protection: write $0 = 32'hFFFF_FFFF, then read rs=0 → 0.
- Flush: instr = beq encoding 0x10A6_0003 with ex_mem_pc_src=1 → control fields 0 at the next edge. With ex_mem_pc_src=0 → id_ex_m = 100, id_ex_ex = 0010, id_ex_sign_ext = 3.
- Unknown opcode 0x3F → all control outputs 0. Asserting rst mid-stream → outputs clear immediately, without waiting for a clock edge.
